// File: rtl/set_pkg.sv
// Shared constants, FSM state type and width helper for the set counter.
package set_pkg;

  // Set expression selects over membership bits a, b, c.
  localparam logic [2:0] MODE_A        = 3'd0;  // a
  localparam logic [2:0] MODE_AANDB    = 3'd1;  // a & b
  localparam logic [2:0] MODE_AXORB    = 3'd2;  // a ^ b
  localparam logic [2:0] MODE_AORB     = 3'd3;  // a | b
  localparam logic [2:0] MODE_TWO_OF_3 = 3'd4;  // exactly two of a, b, c
  localparam logic [2:0] MODE_ALL3     = 3'd5;  // a & b & c
  localparam logic [2:0] MODE_ANY3     = 3'd6;  // a | b | c
  localparam logic [2:0] MODE_ADIFFB   = 3'd7;  // a & ~b

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Number of bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/circle_member.sv
// Two-stage registered test: is lattice point (x,y) inside or on circle (xc,yc,r2)?
module circle_member #(
  parameter int unsigned CW = 4
) (
  input  logic            clk,
  input  logic [CW-1:0]   x_i,
  input  logic [CW-1:0]   y_i,
  input  logic [CW-1:0]   xc_i,
  input  logic [CW-1:0]   yc_i,
  input  logic [2*CW-1:0] r2_i,
  output logic            in_o
);

  localparam int unsigned SW = 2 * CW;

  logic signed [CW:0] dx_c, dy_c;
  logic [CW-1:0]      adx_c, ady_c;
  logic [SW-1:0]      dx2_q, dy2_q;
  logic [SW:0]        s_c;
  logic               in_q;

  // Signed offsets and their magnitudes; squaring the magnitude keeps the product unsigned.
  always_comb begin
    dx_c  = $signed({1'b0, x_i}) - $signed({1'b0, xc_i});
    dy_c  = $signed({1'b0, y_i}) - $signed({1'b0, yc_i});
    adx_c = dx_c[CW] ? CW'(-dx_c) : CW'(dx_c);
    ady_c = dy_c[CW] ? CW'(-dy_c) : CW'(dy_c);
    s_c   = {1'b0, dx2_q} + {1'b0, dy2_q};
  end

  // Stage 1: squared offsets.
  always_ff @(posedge clk) begin
    dx2_q <= SW'(adx_c) * SW'(adx_c);
    dy2_q <= SW'(ady_c) * SW'(ady_c);
  end

  // Stage 2: inclusive full-width compare against r^2.
  always_ff @(posedge clk) begin
    in_q <= (s_c <= {1'b0, r2_i});
  end

  assign in_o = in_q;

endmodule

// File: rtl/set_counter_multi.sv
// Counts lattice points 1..GRID x 1..GRID satisfying a set expression over three circles.
module set_counter_multi
  import set_pkg::*;
#(
  parameter int unsigned GRID  = 8,
  parameter int unsigned CW    = 4,
  parameter int unsigned CNT_W = clog2(GRID * GRID + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [6*CW-1:0]   central,
  input  logic [3*CW-1:0]   radius,
  input  logic [2:0]        mode,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  candidate
);

  localparam int unsigned SW = 2 * CW;

  state_e            state_q;
  logic [6*CW-1:0]   cen_q;
  logic [3*CW-1:0]   rad_q;
  logic [2:0]        mode_q;
  logic [SW-1:0]     r2a_q, r2b_q, r2c_q;
  logic [CW-1:0]     x_q, y_q;
  logic              drain_q;
  logic              busy_q, valid_q;
  logic [CNT_W-1:0]  cand_q;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              v1_q, v2_q;
  logic              accept_c, scan_c, hit_c;
  logic              in_a, in_b, in_c;

  assign accept_c = en && !busy_q && (state_q == ST_IDLE || state_q == ST_DONE);
  assign scan_c   = (state_q == ST_SCAN);

  // Three membership pipelines, one per circle, all fed the same scan point.
  circle_member #(.CW(CW)) u_a (
    .clk(clk), .x_i(x_q), .y_i(y_q),
    .xc_i(cen_q[6*CW-1 -: CW]), .yc_i(cen_q[5*CW-1 -: CW]), .r2_i(r2a_q), .in_o(in_a)
  );
  circle_member #(.CW(CW)) u_b (
    .clk(clk), .x_i(x_q), .y_i(y_q),
    .xc_i(cen_q[4*CW-1 -: CW]), .yc_i(cen_q[3*CW-1 -: CW]), .r2_i(r2b_q), .in_o(in_b)
  );
  circle_member #(.CW(CW)) u_c (
    .clk(clk), .x_i(x_q), .y_i(y_q),
    .xc_i(cen_q[2*CW-1 -: CW]), .yc_i(cen_q[CW-1 -: CW]), .r2_i(r2c_q), .in_o(in_c)
  );

  // Selected set expression and the next accumulator value.
  always_comb begin
    hit_c = 1'b0;
    case (mode_q)
      MODE_A:        hit_c = in_a;
      MODE_AANDB:    hit_c = in_a & in_b;
      MODE_AXORB:    hit_c = in_a ^ in_b;
      MODE_AORB:     hit_c = in_a | in_b;
      MODE_TWO_OF_3: hit_c = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
      MODE_ALL3:     hit_c = in_a & in_b & in_c;
      MODE_ANY3:     hit_c = in_a | in_b | in_c;
      MODE_ADIFFB:   hit_c = in_a & ~in_b;
      default:       hit_c = 1'b0;
    endcase
    acc_d = acc_q + CNT_W'(v2_q && hit_c);
  end

  // Job sequencing, scanner and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cand_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_q <= ST_SCAN;
          x_q     <= CW'(1);
          y_q     <= CW'(1);
        end
        ST_SCAN: begin
          if (x_q == CW'(GRID)) begin
            x_q <= CW'(1);
            if (y_q == CW'(GRID)) begin
              state_q <= ST_DRAIN;
              drain_q <= 1'b0;
            end else begin
              y_q <= y_q + CW'(1);
            end
          end else begin
            x_q <= x_q + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            cand_q  <= acc_d;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operand capture at accept and radius squaring in LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      cen_q  <= '0;
      rad_q  <= '0;
      mode_q <= MODE_A;
      r2a_q  <= '0;
      r2b_q  <= '0;
      r2c_q  <= '0;
    end else begin
      if (accept_c) begin
        cen_q  <= central;
        rad_q  <= radius;
        mode_q <= mode;
      end
      if (state_q == ST_LOAD) begin
        r2a_q <= SW'(rad_q[3*CW-1 -: CW]) * SW'(rad_q[3*CW-1 -: CW]);
        r2b_q <= SW'(rad_q[2*CW-1 -: CW]) * SW'(rad_q[2*CW-1 -: CW]);
        r2c_q <= SW'(rad_q[CW-1 -: CW]) * SW'(rad_q[CW-1 -: CW]);
      end
    end
  end

  // Point-valid tracking through the two membership stages, and the hit accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      v1_q  <= scan_c;
      v2_q  <= v1_q;
      acc_q <= accept_c ? '0 : acc_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign candidate = cand_q;

endmodule

// File: doc/set_counter_multi.md
Name: set_counter_multi

Overview:
- Iterative set-membership counter for circles on a GRID x GRID integer lattice. Lattice points are (x,y), each in 1..GRID.
- Takes three circles A, B and C, each with a centre and a radius. Counts the lattice points that satisfy a selected set expression over A, B and C.
- Parametrised successor of the two-circle, fixed 8x8 set counter in the contest datapath.
- Adds a third circle, configurable grid and coordinate width, eight modes, and a throughput of one point per cycle.

Parameters:
- GRID, 8: lattice edge length. Points run from 1 to GRID on each axis. Range 2..(2^CW - 1).
- CW, 4: width in bits of each centre coordinate and of each radius (unsigned).
- CNT_W, clog2(GRID*GRID+1): width of the candidate count. Derived; not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  job request. Accepted only when busy=0.
- central  in  6*CW  {xa,ya,xb,yb,xc,yc}, MSB first, each CW bits unsigned.
- radius  in  3*CW  {ra,rb,rc}, MSB first, each CW bits unsigned.
- mode  in  3  set expression select. Sampled at accept.
- busy  out  1  high while a job is in progress.
- valid  out  1  one-cycle result strobe.
- candidate  out  CNT_W  point count of the last completed job.

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
  - On reset: busy=0, valid=0, candidate=0, FSM goes to IDLE.
  - Reset mid-job aborts the job; no valid is produced for it.
- Accept:
  - A job is accepted at a rising edge k where en=1 and busy=0.
  - At accept, central, radius and mode are latched.
  - en is ignored while busy=1; it causes no error and no queueing.
- FSM states, in order: IDLE, LOAD, SCAN, DRAIN, DONE, then back to IDLE.
  - IDLE: waits for accept.
  - LOAD: 1 cycle. Squares the radii, r^2 (2*CW bits).
  - SCAN: GRID*GRID cycles. Issues one point per cycle, row-major: y outer, x inner, both starting at 1.
  - DRAIN: 2 cycles. Flushes the membership pipeline.
  - DONE: 1 cycle. valid=1, busy=0, candidate updated. Next edge goes to IDLE.
- Timing:
  - busy=1 from edge k+1 up to, not including, DONE.
  - DONE is entered at edge k+GRID*GRID+3. For GRID=8 that is 67 cycles after accept.
  - A new en in the DONE cycle is accepted, because busy=0 there. This gives back-to-back jobs with no idle gap.
- Membership pipeline (per circle, all three in parallel):
  - Stage 1: dx = x - xc and dy = y - yc, as signed (CW+1)-bit values. Then dx^2 and dy^2, each 2*CW bits unsigned.
  - Stage 2: s = dx^2 + dy^2 (2*CW+1 bits). in = (s <= r^2), inclusive, compared at full width with no truncation.
- Modes, as functions of membership bits a, b, c:
  - 0: a
  - 1: a&b
  - 2: a^b
  - 3: a|b
  - 4: exactly two of a, b, c
  - 5: a&b&c
  - 6: a|b|c
  - 7: a&~b
- Counting:
  - The accumulator increments on each pipeline-output cycle where the selected function is 1.
  - The accumulator clears at accept.
  - candidate is loaded from the accumulator on entry to DONE and held until the next DONE or reset.
- Boundaries:
  - r=0 counts only the centre point, and only if the centre lies on the grid.
  - Centres at 0 or above GRID are legal; the count then covers on-grid points only.
  - A full grid gives GRID*GRID, which must fit in CNT_W without wrap.
  - Unused circles in modes 0-3 and 7 are still computed; their results are ignored.

Decomposition:
- Package set_pkg holds:
  - mode constants MODE_A through MODE_ADIFFB (3-bit);
  - the FSM state enum;
  - a clog2 function for CNT_W.
- One sub-module, circle_member: the 2-stage registered membership test with parameter CW. Inputs are x, y, xc, yc, r2. Output is in. Instantiated 3 times.
- The top level holds the FSM, the x/y scanner, the mode function and the accumulator.

Test Plan:
- Mode 0, A=(4,4), ra=2 -> candidate=13. valid is high exactly 67 cycles after accept and lasts exactly 1 cycle.
- A=(3,3), ra=2 and B=(5,3), rb=2:
  - mode 1 -> 5; mode 2 -> 16; mode 3 -> 21; mode 7 -> 8.
- A=B=C=(4,4), r=2:
  - mode 5 -> 13; mode 6 -> 13; mode 4 -> 0.
- Extreme cases:
  - A=(1,1), ra=15, mode 0 -> 64.
  - A=(0,0), ra=0 -> 0.
  - A=(8,8), ra=0 -> 1.
- Pulse en during SCAN -> ignored, and the current result is unchanged. Assert en in the DONE cycle -> the second job starts, and its valid arrives 67 cycles later.
- Assert rst at the 30th SCAN cycle -> busy=0, valid=0, candidate=0 next cycle, and no valid appears. A new job then returns the correct count.
